// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative signed/unsigned WIDTH x WIDTH multiplier retiring
// BITS_PER_CYCLE multiplier bits per clock behind valid/ready handshakes.
module seq_multiplier #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 ovf
);
    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / B;
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * WIDTH + B;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic                 sgn, neg, accept, res_ovf;
    logic [WIDTH-1:0]     ma, mb;
    logic [AW-1:0]        acc, sum;
    logic [WIDTH+B-1:0]   pp;
    logic [2*WIDTH-1:0]   res;
    logic [CW-1:0]        cnt;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_ready && in_valid && !abort;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = abort           ? IDLE :
                    state == IDLE   ? (in_valid ? BUSY : IDLE) :
                    state == BUSY   ? (cnt == CW'(1) ? FIX : BUSY) :
                    state == FIX    ? DONE :
                    (out_ready ? IDLE : DONE);
    end

    // Partial product lands at weight 2^WIDTH, then the whole accumulator shifts
    // right so the finished product ends up in acc[2*WIDTH-1:0] after N steps.
    always_comb begin
        pp      = {{B{1'b0}}, ma} * {{WIDTH{1'b0}}, mb[B-1:0]};
        sum     = acc + {pp, {WIDTH{1'b0}}};
        res     = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        res_ovf = sgn ? !(&res[2*WIDTH-1:WIDTH-1] || ~|res[2*WIDTH-1:WIDTH-1])
                      : |res[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn  <= 1'b0;
            neg  <= 1'b0;
            ma   <= '0;
            mb   <= '0;
            acc  <= '0;
            cnt  <= '0;
            prod <= '0;
            ovf  <= 1'b0;
        end else begin
            if (accept) begin
                sgn <= is_signed;
                neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                ma  <= is_signed && a[WIDTH-1] ? -a : a;
                mb  <= is_signed && b[WIDTH-1] ? -b : b;
                acc <= '0;
                cnt <= CW'(N);
            end else if (state == BUSY) begin
                acc <= sum >> B;
                mb  <= mb >> B;
                cnt <= cnt - CW'(1);
            end
            if (state == FIX && !abort) begin
                prod <= res;
                ovf  <= res_ovf;
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: checks 64-bit multipliers at 1 and 4 bits/cycle against
// a table of known products and an arithmetic reference model.
module tb_seq_multiplier;
    logic         clk = 0, rst_n = 0, in_valid = 0, is_signed = 0, abort = 0, out_ready = 0;
    logic [63:0]  a = '0, b = '0;
    logic         in_ready1, out_valid1, ovf1, in_ready4, out_valid4, ovf4;
    logic [127:0] prod1, prod4;
    int           vectors = 0, errors = 0;

    typedef struct {
        logic [63:0]  a, b;
        logic         s;
        logic [127:0] p;
        logic         o;
        int           hold;
    } vec_t;
    vec_t tbl[8];

    localparam logic signed [127:0] LIM = 128'sh7FFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .is_signed(is_signed), .abort(abort),
        .out_valid(out_valid1), .out_ready(out_ready), .prod(prod1), .ovf(ovf1));

    seq_multiplier #(.WIDTH(64), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .is_signed(is_signed), .abort(abort),
        .out_valid(out_valid4), .out_ready(out_ready), .prod(prod4), .ovf(ovf4));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [128:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic signed [127:0] p;
        logic o;
        if (s) begin
            p = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
            o = p > LIM || p < -LIM - 1;
        end else begin
            p = {64'b0, x} * {64'b0, y};
            o = (p >> 64) != 0;
        end
        return {o, p};
    endfunction

    task automatic do_op(input string name, input logic [63:0] x, input logic [63:0] y,
                         input logic s, input logic [127:0] ep, input logic eo, input int hold);
        int k = 0, l1 = -1, l4 = -1;
        logic [127:0] p1 = 'x, p4 = 'x;
        logic o1 = 1'bx, o4 = 1'bx;
        @(negedge clk);
        a = x; b = y; is_signed = s; in_valid = 1;
        @(negedge clk);
        in_valid = 0; a = ~x; b = ~y; is_signed = ~s;
        while ((l1 < 0 || l4 < 0) && k < 300) begin
            @(negedge clk);
            k++;
            if (out_valid1 && l1 < 0) begin l1 = k; p1 = prod1; o1 = ovf1; end
            if (out_valid4 && l4 < 0) begin l4 = k; p4 = prod4; o4 = ovf4; end
        end
        chk({name, " prod bpc1"}, p1, ep);
        chk({name, " ovf bpc1"}, 128'(o1), 128'(eo));
        chk({name, " prod bpc4"}, p4, ep);
        chk({name, " ovf bpc4"}, 128'(o4), 128'(eo));
        chk({name, " latency bpc1"}, 128'(l1), 128'(65));
        chk({name, " latency bpc4"}, 128'(l4), 128'(17));
        repeat (hold) begin
            @(negedge clk);
            chk({name, " held prod"}, prod1, p1);
            chk({name, " held in_ready"}, 128'(in_ready1), 128'(0));
            chk({name, " held out_valid"}, 128'(out_valid1), 128'(1));
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({name, " in_ready after take"}, 128'({in_ready1, in_ready4}), 128'(3));
        chk({name, " out_valid after take"}, 128'({out_valid1, out_valid4}), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [128:0] m;
        logic [127:0] last;
        logic seen;
        logic [63:0] x, y;
        logic s;
        tbl = '{
            '{64'd345,     64'd922,      1'b0, 128'd318090,        1'b0, 0},
            '{-64'sd345,   64'd22,       1'b1, -128'sd7590,        1'b0, 0},
            '{-64'sd345,   -64'sd22,     1'b1, 128'd7590,          1'b0, 0},
            '{'1,          '1,           1'b0, 128'hFFFFFFFFFFFFFFFE_0000000000000001, 1'b1, 0},
            '{'1,          '1,           1'b1, 128'd1,             1'b0, 0},
            '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
              128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 0},
            '{64'd4567889, 64'd23482390, 1'b0, 128'd107264950974710, 1'b0, 10},
            '{64'd0,       '1,           1'b1, 128'd0,             1'b0, 0}
        };
        repeat (2) @(negedge clk);
        chk("reset in_ready", 128'({in_ready1, in_ready4}), 128'(3));
        chk("reset out_valid", 128'({out_valid1, out_valid4}), 128'(0));
        chk("reset prod", prod1 | prod4, 128'(0));
        chk("reset ovf", 128'({ovf1, ovf4}), 128'(0));
        rst_n = 1;

        foreach (tbl[i])
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, tbl[i].o, tbl[i].hold);

        // abort during BUSY (bpc4 copy is already in DONE by then)
        last = prod1;
        @(negedge clk);
        a = 64'd1234; b = 64'd5678; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (19) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort in_ready", 128'({in_ready1, in_ready4}), 128'(3));
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            seen |= out_valid1 | out_valid4;
        end
        chk("abort no out_valid", 128'(seen), 128'(0));
        chk("abort prod kept", prod1, last);
        do_op("after abort", 64'd1234, 64'd5678, 1'b0, 128'd7006652, 1'b0, 0);

        // asynchronous reset mid-BUSY
        @(negedge clk);
        a = 64'd99; b = 64'd77; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (10) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async reset prod", prod1 | prod4, 128'(0));
        chk("async reset ovf", 128'({ovf1, ovf4}), 128'(0));
        chk("async reset in_ready", 128'({in_ready1, in_ready4}), 128'(3));
        chk("async reset out_valid", 128'({out_valid1, out_valid4}), 128'(0));
        @(negedge clk);
        rst_n = 1;
        do_op("after reset", -64'sd99, 64'd77, 1'b1, -128'sd7623, 1'b0, 0);

        // abort in IDLE blocks acceptance
        @(negedge clk);
        a = 64'd5; b = 64'd6; in_valid = 1; abort = 1;
        @(negedge clk);
        in_valid = 0; abort = 0;
        chk("idle abort no accept", 128'({in_ready1, in_ready4}), 128'(3));
        do_op("after idle abort", 64'd5, 64'd6, 1'b0, 128'd30, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            x = {$urandom, $urandom} >> $urandom_range(0, 63);
            y = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (s && $urandom_range(0, 1) == 1) x = -x;
            if (s && $urandom_range(0, 1) == 1) y = -y;
            m = model(x, y, s);
            do_op($sformatf("rand%0d", i), x, y, s, m[127:0], m[128], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised iterative integer multiplier for the ALU. It multiplies two WIDTH-bit operands in either signed or unsigned mode and returns the full 2·WIDTH-bit product plus an overflow flag. The flag is set when the product does not fit in WIDTH bits. It retires BITS_PER_CYCLE multiplier bits per clock behind valid/ready handshakes, which trades latency for area against the single-cycle multiplier.

## Interface
- WIDTH, 64: operand width in bits; even, ≥ 4.
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration; one of 1, 2, 4; must divide WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- abort  in  1  synchronous cancel of any operation in flight.
- out_valid  out  1  prod/ovf valid.
- out_ready  in  1  consumer takes result.
- prod  out  2·WIDTH  full product.
- ovf  out  1  product not representable in WIDTH bits in the selected mode.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE: in_ready=1.
  - On in_valid && !abort: capture is_signed, |a|, |b| (magnitudes only when is_signed; the most-negative value maps to 2^(WIDTH-1), which fits in WIDTH unsigned bits).
  - Capture result sign = a[MSB]^b[MSB] when signed, else 0.
  - Clear the accumulator, load iteration counter N = WIDTH/BITS_PER_CYCLE, go to BUSY.
- BUSY: each cycle adds |a| × (low BITS_PER_CYCLE bits of remaining |b|) into the accumulator at the proper weight, shifts, and decrements the counter. When the counter reaches 0, go to FIX.
- FIX: conditionally two's-complement-negate the 2·WIDTH magnitude, register prod and ovf, go to DONE.
- DONE: out_valid=1; prod and ovf held stable. On out_ready, go to IDLE (out_valid drops next cycle).
- Overflow rule:
  - Unsigned: ovf = |prod[2W-1:W].
  - Signed: ovf = 1 unless prod[2W-1:W-1] is all zeros or all ones.
- Arithmetic: accumulator is 2·WIDTH+BITS_PER_CYCLE bits internally; no truncation before FIX. Zero operands take the full latency (no early exit).
- abort: in any state, go to IDLE on the next edge; out_valid=0; prod/ovf keep their last registered value. In IDLE, abort suppresses acceptance even with in_valid=1.
- No operand overlap: in_ready=0 in BUSY, FIX and DONE. Operand inputs are don't-care outside the accept cycle.

## Timing
- Reset (rst_n low, any time, including mid-operation): state=IDLE, in_ready=1, out_valid=0, prod=0, ovf=0, counter=0. Takes effect immediately, not clock-gated.
- Accept edge E0 (in_valid && in_ready). BUSY occupies edges E1..EN; FIX at E(N+1); out_valid high after E(N+1).
  - Latency = WIDTH/BITS_PER_CYCLE + 1 cycles: 65 for 64/1, 17 for 64/4.
- out_valid with out_ready=1 on the same cycle: result consumed at that edge, in_ready high next cycle. Earliest next accept is one cycle after the result is consumed.
- out_ready held low: DONE persists indefinitely with stable outputs.
- Throughput: one result per (latency + 2) cycles at best.

## Test plan
- WIDTH=64, BPC=1, unsigned: a=345, b=922 → prod=318090, ovf=0, out_valid exactly 65 cycles after accept.
- Signed: a=-345, b=22 → prod=-7590 sign-extended to 128 bits, ovf=0. Then a=-345, b=-22 → prod=7590, ovf=0.
- a=b=64'hFFFF_FFFF_FFFF_FFFF:
  - Unsigned → prod=128'hFFFFFFFFFFFFFFFE_0000000000000001, ovf=1.
  - Signed → prod=1, ovf=0.
- Signed a=b=64'h8000_0000_0000_0000 → prod=128'h4000_0000_0000_0000_0000_0000_0000_0000, ovf=1. With BPC=4: same result, out_valid 17 cycles after accept.
- Unsigned a=4567889, b=23482390 → prod=107264950974710, ovf=0. Hold out_ready=0 for 10 cycles: prod stable, in_ready=0; release → in_ready=1 next cycle.
- Reset and abort:
  - Assert abort at BUSY cycle 20 → next cycle IDLE, in_ready=1, out_valid never asserts.
  - Pull rst_n low mid-BUSY → outputs zero asynchronously.
  - abort with in_valid in IDLE → no accept.
  - A fresh operation after either case returns the correct product.
